// File: rtl/reset_gen_pkg.sv
`default_nettype none
// ============================================================================
// Module      : reset_gen_pkg
// Description : Shared types and constants for the reset generator.
// Revision    : 1.0 - initial release
// ============================================================================
package reset_gen_pkg;

    typedef enum logic [1:0] {
        RESET   = 2'd0,
        HOLD    = 2'd1,
        RUN     = 2'd2,
        SW_HOLD = 2'd3
    } state_t;

    localparam logic [1:0] CAUSE_NONE = 2'b00;
    localparam logic [1:0] CAUSE_EXT  = 2'b01;
    localparam logic [1:0] CAUSE_SW   = 2'b10;

    localparam logic [7:0] SW_CNT_MAX = 8'hFF;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == SW_CNT_MAX) ? v : v + 8'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/reset_sync.sv
`default_nettype none
// ============================================================================
// Module      : reset_sync
// Description : Async-assert / sync-deassert reset synchronizer chain.
// Revision    : 1.0 - initial release
// ============================================================================
module reset_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    output logic rst_sync_n
);

    logic [SYNC_STAGES-1:0] r_sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], 1'b1};
        end
    end

    assign rst_sync_n = r_sync[SYNC_STAGES-1];

endmodule
`default_nettype wire

// File: rtl/reset_gen.sv
`default_nettype none
// ============================================================================
// Module      : reset_gen
// Description : Synchronizes board reset, stretches a synchronous reset,
//               handles software reset requests and reports reset cause.
// Revision    : 1.0 - initial release
// ============================================================================
module reset_gen
    import reset_gen_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int HOLD_CYCLES = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sw_rst_req,
    output logic       rst_sync_n,
    output logic       rst_o,
    output logic       ready_o,
    output logic [1:0] rst_cause_o,
    output logic [7:0] sw_cnt_o
);

    localparam int                 c_CNT_W     = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [c_CNT_W-1:0] c_HOLD_LOAD = c_CNT_W'(HOLD_CYCLES - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE   = c_CNT_W'(1);

    logic               w_rst_sync_n;
    state_t             r_state;
    logic [c_CNT_W-1:0] r_cnt;
    logic               r_rst;
    logic [1:0]         r_cause;
    logic [7:0]         r_sw_cnt;

    reset_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_reset_sync (
        .clk        (clk),
        .rst_n      (rst_n),
        .rst_sync_n (w_rst_sync_n)
    );

    // Every branch sets r_rst to (next state != RUN) so rst_o is a clean flop output.
    always_ff @(posedge clk or negedge w_rst_sync_n) begin
        if (!w_rst_sync_n) begin
            r_state  <= RESET;
            r_cnt    <= '0;
            r_rst    <= 1'b1;
            r_cause  <= CAUSE_EXT;
            r_sw_cnt <= 8'd0;
        end else begin
            case (r_state)
                RESET: begin
                    r_state <= HOLD;
                    r_cnt   <= c_HOLD_LOAD;
                    r_rst   <= 1'b1;
                end
                HOLD, SW_HOLD: begin
                    if (r_cnt == '0) begin
                        r_state <= RUN;
                        r_rst   <= 1'b0;
                    end else begin
                        r_cnt   <= r_cnt - c_CNT_ONE;
                        r_rst   <= 1'b1;
                    end
                end
                RUN: begin
                    if (sw_rst_req) begin
                        r_state  <= SW_HOLD;
                        r_cnt    <= c_HOLD_LOAD;
                        r_rst    <= 1'b1;
                        r_cause  <= CAUSE_SW;
                        r_sw_cnt <= sat_inc(r_sw_cnt);
                    end else begin
                        r_rst    <= 1'b0;
                    end
                end
                default: begin
                    r_state <= RESET;
                    r_rst   <= 1'b1;
                end
            endcase
        end
    end

    assign rst_sync_n  = w_rst_sync_n;
    assign rst_o       = r_rst;
    assign ready_o     = ~r_rst;
    assign rst_cause_o = r_cause;
    assign sw_cnt_o    = r_sw_cnt;

endmodule
`default_nettype wire

// File: tb/tb_reset_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_reset_gen
// Description : Scoreboard bench for reset_gen (default and minimum params).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_reset_gen;
    import reset_gen_pkg::*;

    typedef struct {
        int         edge_n;
        logic       val;
        logic [1:0] cause;
        logic [7:0] cnt;
    } ev_t;

    typedef struct {
        logic       rsn;
        logic       ro;
        logic [7:0] cnt;
    } cyc_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n = 1'b1, sw_rst_req = 1'b0;
    logic       rst_sync_n, rst_o, ready_o;
    logic [1:0] rst_cause_o;
    logic [7:0] sw_cnt_o;

    logic       rst_n2 = 1'b1, sw2 = 1'b0;
    logic       rsn2, ro2, rdy2;
    logic [1:0] cause2;
    logic [7:0] cnt2;

    reset_gen dut (
        .clk(clk), .rst_n(rst_n), .sw_rst_req(sw_rst_req), .rst_sync_n(rst_sync_n),
        .rst_o(rst_o), .ready_o(ready_o), .rst_cause_o(rst_cause_o), .sw_cnt_o(sw_cnt_o)
    );

    reset_gen #(.SYNC_STAGES(3), .HOLD_CYCLES(1)) dut_min (
        .clk(clk), .rst_n(rst_n2), .sw_rst_req(sw2), .rst_sync_n(rsn2),
        .rst_o(ro2), .ready_o(rdy2), .rst_cause_o(cause2), .sw_cnt_o(cnt2)
    );

    int   n_checks = 0, n_err = 0, cnt_edge = 0;
    ev_t  q_rst[$], q_sync[$];
    cyc_t q2[$];
    logic mon_en = 1'b0, prev_rst, prev_sync;
    ev_t  mon_e;
    cyc_t mon_c;

    always @(posedge clk) cnt_edge <= cnt_edge + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic ev_t mk(input int e, input logic v, input logic [1:0] c, input logic [7:0] n);
        ev_t x;
        x.edge_n = e; x.val = v; x.cause = c; x.cnt = n;
        return x;
    endfunction

    function automatic cyc_t mkc(input logic rsn, input logic ro, input logic [7:0] n);
        cyc_t x;
        x.rsn = rsn; x.ro = ro; x.cnt = n;
        return x;
    endfunction

    // Default-parameter monitor: every transition of rst_o / rst_sync_n consumes one expectation.
    always @(negedge clk) begin
        if (mon_en) begin
            if (rst_sync_n !== prev_sync) begin
                if (q_sync.size() == 0) chk("sync_unexpected_change", rst_sync_n, prev_sync);
                else begin
                    mon_e = q_sync.pop_front();
                    if (mon_e.edge_n >= 0) chk("sync_edge", cnt_edge, mon_e.edge_n);
                    chk("sync_val", rst_sync_n, mon_e.val);
                end
                prev_sync = rst_sync_n;
            end
            if (rst_o !== prev_rst) begin
                if (q_rst.size() == 0) chk("rst_unexpected_change", rst_o, prev_rst);
                else begin
                    mon_e = q_rst.pop_front();
                    if (mon_e.edge_n >= 0) chk("rst_edge", cnt_edge, mon_e.edge_n);
                    chk("rst_o", rst_o, mon_e.val);
                    chk("ready_o", ready_o, !mon_e.val);
                    chk("rst_cause", rst_cause_o, mon_e.cause);
                    chk("sw_cnt", sw_cnt_o, mon_e.cnt);
                end
                prev_rst = rst_o;
            end
        end
    end

    // Minimum-parameter monitor: one expectation per cycle while entries are queued.
    always @(negedge clk) begin
        if (q2.size() != 0) begin
            mon_c = q2.pop_front();
            chk("min_rst_sync_n", rsn2, mon_c.rsn);
            chk("min_rst_o", ro2, mon_c.ro);
            chk("min_ready_o", rdy2, !mon_c.ro);
            chk("min_sw_cnt", cnt2, mon_c.cnt);
        end
    end

    task automatic wait_edge(input int n);
        while (cnt_edge < n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drain(input int max_edges);
        int k = 0;
        while ((q_rst.size() + q_sync.size() + q2.size()) != 0 && k < max_edges) begin
            @(negedge clk);
            #1;
            k++;
        end
        chk("drain_timeout", q_rst.size() + q_sync.size() + q2.size(), 0);
    endtask

    task automatic sw_pulse(input logic [7:0] exp_cnt, input bit push_fall, output int s);
        @(posedge clk);
        #1 sw_rst_req = 1'b1;
        s = cnt_edge + 1;
        q_rst.push_back(mk(s, 1'b1, CAUSE_SW, exp_cnt));
        if (push_fall) q_rst.push_back(mk(s + 16, 1'b0, CAUSE_SW, exp_cnt));
        @(posedge clk);
        #1 sw_rst_req = 1'b0;
    endtask

    task automatic chk_reset_vals();
        chk("async_rst_sync_n", rst_sync_n, 0);
        chk("async_rst_o", rst_o, 1);
        chk("async_ready_o", ready_o, 0);
        chk("async_cause", rst_cause_o, CAUSE_EXT);
        chk("async_sw_cnt", sw_cnt_o, 0);
    endtask

    initial begin
        int rel, s, cur;
        // Let both synchronizers fill so the reset assertion is a real falling edge.
        repeat (4) @(posedge clk);
        #2 rst_n = 1'b0; rst_n2 = 1'b0;
        #1 chk_reset_vals();
        chk("min_async_rst_o", ro2, 1);
        chk("min_async_rst_sync_n", rsn2, 0);
        prev_sync = rst_sync_n; prev_rst = rst_o; mon_en = 1'b1;

        // Power-on release mid-cycle.
        repeat (5) @(posedge clk);
        #3 rst_n = 1'b1;
        rel = cnt_edge;
        q_sync.push_back(mk(rel + 2, 1'b1, CAUSE_EXT, 8'd0));
        q_rst.push_back(mk(rel + 19, 1'b0, CAUSE_EXT, 8'd0));
        drain(40);

        // Single software reset.
        sw_pulse(8'd1, 1'b1, s);
        drain(40);

        // Requests during SW_HOLD, including its final edge, are ignored.
        sw_pulse(8'd2, 1'b1, s);
        wait_edge(s + 4); sw_rst_req = 1'b1;
        wait_edge(s + 5); sw_rst_req = 1'b0;
        wait_edge(s + 13); sw_rst_req = 1'b1;
        wait_edge(s + 16); sw_rst_req = 1'b0;
        drain(40);

        // Raise count to 5, then a 3 ns reset pulse in the middle of SW_HOLD.
        sw_pulse(8'd3, 1'b1, s); drain(40);
        sw_pulse(8'd4, 1'b1, s); drain(40);
        sw_pulse(8'd5, 1'b0, s);
        wait_edge(s + 6);
        q_sync.push_back(mk(-1, 1'b0, CAUSE_EXT, 8'd0));
        rst_n = 1'b0;
        #1 chk_reset_vals();
        #2 rst_n = 1'b1;
        rel = cnt_edge;
        q_sync.push_back(mk(rel + 2, 1'b1, CAUSE_EXT, 8'd0));
        q_rst.push_back(mk(rel + 19, 1'b0, CAUSE_EXT, 8'd0));
        // Requests during HOLD must neither count nor stretch.
        wait_edge(rel + 8); sw_rst_req = 1'b1;
        wait_edge(rel + 10); sw_rst_req = 1'b0;
        drain(40);

        // Continuous request: 300 back-to-back resets, count saturates.
        @(posedge clk);
        #1 sw_rst_req = 1'b1;
        s = cnt_edge + 1;
        for (int k = 0; k < 300; k++) begin
            logic [7:0] n;
            n = (k + 1 > 255) ? 8'd255 : 8'(k + 1);
            q_rst.push_back(mk(s + 17 * k, 1'b1, CAUSE_SW, n));
            q_rst.push_back(mk(s + 17 * k + 16, 1'b0, CAUSE_SW, n));
        end
        wait_edge(s + 17 * 299);
        sw_rst_req = 1'b0;
        drain(40);
        repeat (5) @(posedge clk);
        #1 chk("sat_final_cnt", sw_cnt_o, 255);

        // Minimum parameters: SYNC_STAGES=3, HOLD_CYCLES=1.
        @(posedge clk);
        #2 rst_n2 = 1'b1;
        rel = cnt_edge;
        for (int e = rel; e <= rel + 7; e++)
            q2.push_back(mkc(e >= rel + 3, e < rel + 5, 8'd0));
        drain(20);
        @(posedge clk);
        #1 sw2 = 1'b1;
        cur = cnt_edge;
        for (int e = cur; e <= cur + 4; e++)
            q2.push_back(mkc(1'b1, e == cur + 1, (e >= cur + 1) ? 8'd1 : 8'd0));
        @(posedge clk);
        #1 sw2 = 1'b0;
        drain(20);
        chk("min_cause", cause2, CAUSE_SW);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, time %0t, expected under 500000", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
